// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - SVGA 800x600@60 timing defaults, pattern mode enum and RGB pixel type.
package video_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;
  localparam int DEF_POS_W    = 11;
  localparam int DEF_COLOR_W  = 4;
  localparam int DEF_SQ_LOG2  = 5;

  typedef enum logic [1:0] {
    MODE_CHECKER = 2'd0,
    MODE_SCROLL  = 2'd1,
    MODE_BARS    = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_t;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/video_timing.sv
// rtl/video_timing.sv - h/v position counters with active, sync and frame-boundary decode.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int POS_W     = DEF_POS_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [POS_W-1:0] h_o,
  output logic [POS_W-1:0] v_o,
  output logic             active_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             line_end_o,
  output logic             frame_strobe_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_ACT    = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_ACT    = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] HS_START = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] HS_END   = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] VS_START = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] VS_END   = POS_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [POS_W-1:0] h_q, h_d;
  logic [POS_W-1:0] v_q, v_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  assign h_o            = h_q;
  assign v_o            = v_q;
  assign active_o       = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_o        = ((h_q >= HS_START) && (h_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_o        = ((v_q >= VS_START) && (v_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  assign line_end_o     = (h_q == H_LAST);
  assign frame_strobe_o = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/squares_gen.sv
// rtl/squares_gen.sv - pattern engine and aligned output pipe driving VGA DAC pins.
// Optional per-frame horizontal scroll of mode 1 is built when SQUARES_SCROLL_EN is defined.
module squares_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE       = DEF_H_ACTIVE,
  parameter int H_FP           = DEF_H_FP,
  parameter int H_SYNC         = DEF_H_SYNC,
  parameter int H_BP           = DEF_H_BP,
  parameter int V_ACTIVE       = DEF_V_ACTIVE,
  parameter int V_FP           = DEF_V_FP,
  parameter int V_SYNC         = DEF_V_SYNC,
  parameter int V_BP           = DEF_V_BP,
  parameter bit HSYNC_POL      = 1'b1,
  parameter bit VSYNC_POL      = 1'b1,
  parameter int POS_W          = DEF_POS_W,
  parameter int COLOR_W        = DEF_COLOR_W,
  parameter int SQ_LOG2        = DEF_SQ_LOG2,
  parameter int PIPELINE_DELAY = 1
) (
  input  logic                 clk40,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] fg_color,
  input  logic [3*COLOR_W-1:0] bg_color,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_active,
  output logic                 frame_start,
  output logic [POS_W-1:0]     h_pos,
  output logic [POS_W-1:0]     v_pos
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [POS_W-1:0] BAR_LAST = POS_W'(BAR_W - 1);

  typedef struct packed {
    logic [3*COLOR_W-1:0] rgb;
    logic                 hsync;
    logic                 vsync;
    logic                 active;
    logic                 fs;
  } pipe_t;

  localparam pipe_t PIPE_RST = '{rgb: '0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL,
                                 active: 1'b0, fs: 1'b0};

  logic [POS_W-1:0] h, v;
  logic             active, hs, vs, line_end, frame_strobe;

  video_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .POS_W(POS_W)
  ) u_timing (
    .clk_i          (clk40),
    .rst_ni         (rst_n),
    .h_o            (h),
    .v_o            (v),
    .active_o       (active),
    .hsync_o        (hs),
    .vsync_o        (vs),
    .line_end_o     (line_end),
    .frame_strobe_o (frame_strobe)
  );

  // Pixel (0,0) already uses the newly sampled mode, so a frame never mixes modes.
  mode_t mode_q, mode_eff;
  assign mode_eff = frame_strobe ? mode_t'(mode) : mode_q;

  logic x_scroll;
`ifdef SQUARES_SCROLL_EN
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [POS_W-1:0] scroll_x;

  // Advancing on the wrap into (0,0) makes the whole new frame see the new count.
  assign frame_cnt_d = (line_end && (v == V_LAST)) ? frame_cnt_q + 8'd1 : frame_cnt_q;
  assign scroll_x    = h + POS_W'(frame_cnt_q);
  assign x_scroll    = scroll_x[SQ_LOG2];

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= 8'd0;
    else        frame_cnt_q <= frame_cnt_d;
  end
`else
  assign x_scroll = h[SQ_LOG2];
`endif

  logic [POS_W-1:0] px_q, px_d;
  logic [2:0]       bar_q, bar_d;

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_CHECKER;
      px_q   <= '0;
      bar_q  <= 3'd0;
    end else begin
      mode_q <= mode_eff;
      px_q   <= px_d;
      bar_q  <= bar_d;
    end
  end

  // Bar index tracks h without a divider; the last bar absorbs the truncation remainder.
  always_comb begin
    px_d  = px_q;
    bar_d = bar_q;
    if (line_end) begin
      px_d  = '0;
      bar_d = 3'd0;
    end else if (bar_q != 3'd7) begin
      if (px_q == BAR_LAST) begin
        px_d  = '0;
        bar_d = bar_q + 3'd1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  logic [2:0]           bar_code;
  logic [3*COLOR_W-1:0] bar_rgb, pix;
  pipe_t                stage_in;

  assign bar_code = 3'd7 - bar_q;
  assign bar_rgb  = {{COLOR_W{bar_code[2]}}, {COLOR_W{bar_code[1]}}, {COLOR_W{bar_code[0]}}};

  always_comb begin
    pix = bg_color;
    case (mode_eff)
      MODE_CHECKER: pix = (h[SQ_LOG2] ^ v[SQ_LOG2]) ? fg_color : bg_color;
      MODE_SCROLL:  pix = (x_scroll ^ v[SQ_LOG2]) ? fg_color : bg_color;
      MODE_BARS:    pix = bar_rgb;
      MODE_SOLID:   pix = fg_color;
      default:      pix = bg_color;
    endcase
    if (!active) pix = '0;
  end

  assign stage_in = '{rgb: pix, hsync: hs, vsync: vs, active: active, fs: frame_strobe};

  pipe_t pipe_q [PIPELINE_DELAY];

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPELINE_DELAY; i++) pipe_q[i] <= PIPE_RST;
    end else begin
      pipe_q[0] <= stage_in;
      for (int i = 1; i < PIPELINE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {red, green, blue} = pipe_q[PIPELINE_DELAY-1].rgb;
  assign hsync              = pipe_q[PIPELINE_DELAY-1].hsync;
  assign vsync              = pipe_q[PIPELINE_DELAY-1].vsync;
  assign video_active       = pipe_q[PIPELINE_DELAY-1].active;
  assign frame_start        = pipe_q[PIPELINE_DELAY-1].fs;
  assign h_pos              = h;
  assign v_pos              = v;

endmodule

// File: tb/tb_squares_gen.sv
// tb/tb_squares_gen.sv - directed checks of squares_gen on a reduced timing with a 2-stage pipe.
module tb_squares_gen;

  localparam int HA = 164, HF = 8, HS = 16, HB = 12;
  localparam int VA = 40,  VF = 1, VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int D = 2;
`ifdef SQUARES_SCROLL_EN
  localparam int SC = 4;
`else
  localparam int SC = 0;
`endif

  logic        clk40 = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] fg_color = 12'hF00;
  logic [11:0] bg_color = 12'h00F;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, video_active, frame_start;
  logic [10:0] h_pos, v_pos;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #12.5 clk40 = ~clk40;

  squares_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .POS_W(11), .COLOR_W(4),
    .SQ_LOG2(5), .PIPELINE_DELAY(D)
  ) dut (
    .clk40(clk40), .rst_n(rst_n), .mode(mode), .fg_color(fg_color), .bg_color(bg_color),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .video_active(video_active), .frame_start(frame_start), .h_pos(h_pos), .v_pos(v_pos)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk40);
      #1;
      cyc += n;
    end
  endtask

  // Advance until the pins show pixel (x,y) of frame f, counted from the last reset release.
  task automatic go_pin(input int f, input int x, input int y);
    int tgt;
    tgt = f * FRAME + y * HT + x + D;
    if (tgt < cyc) begin
      n_cmp++;
      n_err++;
      $error("FAIL seq target=%0d behind cycle=%0d", tgt, cyc);
    end else begin
      step(tgt - cyc);
    end
  endtask

  function automatic logic [11:0] rgb();
    return {red, green, blue};
  endfunction

  initial begin
    #(100000 * 25);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_hi, hs_rise, vs_hi, act_n, fs_n;
    logic hs_prev;

    repeat (10) @(posedge clk40);
    #1;
    chk("rst_rgb", 32'(rgb()), 32'h000);
    chk("rst_hsync", 32'(hsync), 32'd0);
    chk("rst_vsync", 32'(vsync), 32'd0);
    chk("rst_active", 32'(video_active), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_hpos", 32'(h_pos), 32'd0);

    @(negedge clk40);
    rst_n = 1'b1;
    cyc = 0;
    chk("rel_fs0", 32'(frame_start), 32'd0);
    step(D - 1);
    chk("rel_fs_early", 32'(frame_start), 32'd0);

    go_pin(0, 0, 0);
    chk("f0_fs", 32'(frame_start), 32'd1);
    chk("f0_active", 32'(video_active), 32'd1);
    chk("chk_0_0", 32'(rgb()), 32'h00F);
    chk("hpos_undelayed", 32'(h_pos), 32'(D));
    go_pin(0, 31, 0);  chk("chk_31_0", 32'(rgb()), 32'h00F);
    go_pin(0, 32, 0);  chk("chk_32_0", 32'(rgb()), 32'hF00);
    go_pin(0, 163, 0); chk("last_active", 32'(video_active), 32'd1);
    go_pin(0, 164, 0);
    chk("blank_rgb", 32'(rgb()), 32'h000);
    chk("blank_active", 32'(video_active), 32'd0);
    go_pin(0, 171, 0); chk("hs_pre", 32'(hsync), 32'd0);
    go_pin(0, 172, 0); chk("hs_start", 32'(hsync), 32'd1);
    go_pin(0, 187, 0); chk("hs_last", 32'(hsync), 32'd1);
    go_pin(0, 188, 0); chk("hs_end", 32'(hsync), 32'd0);

    go_pin(0, 0, 20);
    mode = 2'd3;
    go_pin(0, 32, 32); chk("midframe_chk", 32'(rgb()), 32'h00F);
    go_pin(0, 0, 40);  chk("vs_pre", 32'(vsync), 32'd0);
    go_pin(0, 0, 41);  chk("vs_start", 32'(vsync), 32'd1);
    go_pin(0, 199, 42); chk("vs_last", 32'(vsync), 32'd1);
    go_pin(0, 0, 43);  chk("vs_end", 32'(vsync), 32'd0);
    go_pin(0, 199, 45); chk("f0_end_fs", 32'(frame_start), 32'd0);

    go_pin(1, 0, 0);
    chk("f1_fs", 32'(frame_start), 32'd1);
    chk("solid_0_0", 32'(rgb()), 32'hF00);
    go_pin(1, 10, 5);
    chk("solid_10_5", 32'(rgb()), 32'hF00);
    fg_color = 12'h0A5;
    go_pin(1, 11, 5);  chk("fg_old", 32'(rgb()), 32'hF00);
    go_pin(1, 12, 5);  chk("fg_new", 32'(rgb()), 32'h0A5);
    fg_color = 12'hF00;
    go_pin(1, 170, 5); chk("solid_blank", 32'(rgb()), 32'h000);
    go_pin(1, 0, 30);
    mode = 2'd2;

    hs_hi = 0; hs_rise = 0; vs_hi = 0; act_n = 0; fs_n = 0; hs_prev = 1'b0;
    go_pin(2, 0, 0);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) step(1);
      if (hsync) hs_hi++;
      if (hsync && !hs_prev) hs_rise++;
      if (vsync) vs_hi++;
      if (video_active) act_n++;
      if (frame_start) fs_n++;
      hs_prev = hsync;
    end
    chk("frm_hs_cycles", 32'(hs_hi), 32'(VT * HS));
    chk("frm_hs_pulses", 32'(hs_rise), 32'(VT));
    chk("frm_vs_cycles", 32'(vs_hi), 32'(VS * HT));
    chk("frm_active", 32'(act_n), 32'(HA * VA));
    chk("frm_fs_count", 32'(fs_n), 32'd1);

    go_pin(3, 0, 10);   chk("bar_0", 32'(rgb()), 32'hFFF);
    go_pin(3, 19, 10);  chk("bar_19", 32'(rgb()), 32'hFFF);
    go_pin(3, 20, 10);  chk("bar_20", 32'(rgb()), 32'hFF0);
    go_pin(3, 40, 10);  chk("bar_40", 32'(rgb()), 32'hF0F);
    go_pin(3, 100, 10); chk("bar_100", 32'(rgb()), 32'h0F0);
    go_pin(3, 139, 10); chk("bar_139", 32'(rgb()), 32'h00F);
    go_pin(3, 140, 10); chk("bar_140", 32'(rgb()), 32'h000);
    go_pin(3, 163, 10);
    chk("bar_tail", 32'(rgb()), 32'h000);
    chk("bar_tail_act", 32'(video_active), 32'd1);
    go_pin(3, 0, 30);
    mode = 2'd1;

    go_pin(4, 31 - SC, 0); chk("scroll_bg", 32'(rgb()), 32'h00F);
    go_pin(4, 32 - SC, 0); chk("scroll_fg", 32'(rgb()), 32'hF00);
    go_pin(4, 0, 10);
    mode = 2'd0;

    go_pin(5, 0, 20);
    #5;
    rst_n = 1'b0;
    #1;
    chk("mrst_rgb", 32'(rgb()), 32'h000);
    chk("mrst_active", 32'(video_active), 32'd0);
    chk("mrst_hsync", 32'(hsync), 32'd0);
    chk("mrst_vpos", 32'(v_pos), 32'd0);
    repeat (3) @(posedge clk40);
    @(negedge clk40);
    rst_n = 1'b1;
    cyc = 0;
    go_pin(0, 0, 0);
    chk("mrst_fs", 32'(frame_start), 32'd1);
    chk("mrst_0_0", 32'(rgb()), 32'h00F);
    go_pin(0, 31, 0); chk("mrst_31_0", 32'(rgb()), 32'h00F);
    go_pin(0, 32, 0); chk("mrst_32_0", 32'(rgb()), 32'hF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
